// File: rtl/stream_demux.sv
// Registered, packet-aware 1-to-N_CH stream demultiplexer with a one-deep register per output.
// Build option: define STREAM_DEMUX_DROP_EN to accept and discard packets whose sel is out of range.
module stream_demux #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 8,
  parameter int SEL_W  = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_W-1:0]      s_data_i,
  input  logic                   s_valid_i,
  input  logic                   s_last_i,
  output logic                   s_ready_o,
  input  logic [SEL_W-1:0]       sel_i,
  output logic [N_CH*DATA_W-1:0] m_data_o,
  output logic [N_CH-1:0]        m_valid_o,
  output logic [N_CH-1:0]        m_last_o,
  input  logic [N_CH-1:0]        m_ready_i,
  output logic                   busy_o,
  output logic                   drop_o,
  output logic                   state_o
);

  // Handshake: a beat transfers on any edge where valid & ready are both 1; valid never waits on ready.
  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_e;

  localparam logic [SEL_W:0] N_CH_L = (SEL_W + 1)'(N_CH);

  generate
    if (N_CH < 2 || N_CH > (1 << SEL_W)) begin : g_bad_cfg
      $error("stream_demux: N_CH must be in 2..2**SEL_W");
    end
  endgenerate

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        lock_q, lock_d;
  logic [SEL_W-1:0]        tgt;
  logic                    in_range;
  logic                    tgt_vld;
  logic                    tgt_rdy;
  logic                    accept;
  logic [N_CH-1:0]         load;
  logic [N_CH-1:0]         m_valid_q, m_valid_d;
  logic [N_CH-1:0]         m_last_q, m_last_d;
  logic [N_CH*DATA_W-1:0]  m_data_q, m_data_d;

  // The first beat of a packet routes on sel; later beats follow the locked channel.
  assign tgt      = (state_q == IDLE) ? sel_i : lock_q;
  assign in_range = ({1'b0, tgt} < N_CH_L);

  always_comb begin
    tgt_vld = 1'b0;
    tgt_rdy = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (tgt == SEL_W'(k)) begin
        tgt_vld = m_valid_q[k];
        tgt_rdy = m_ready_i[k];
      end
    end
  end

`ifdef STREAM_DEMUX_DROP_EN
  assign s_ready_o = !rst_i && (!in_range || !tgt_vld || tgt_rdy);
`else
  assign s_ready_o = !rst_i && in_range && (!tgt_vld || tgt_rdy);
`endif

  assign accept = s_valid_i && s_ready_o;

  always_comb begin
    load = '0;
    for (int k = 0; k < N_CH; k++) begin
      load[k] = accept && (tgt == SEL_W'(k));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          lock_d = sel_i;
          if (!s_last_i) state_d = PKT;
        end
      end
      PKT: begin
        if (accept && s_last_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_q == PKT);
    state_o = state_q;
  end

  // A load wins over a drain of the same channel, so back-to-back beats keep valid high.
  always_comb begin
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    for (int k = 0; k < N_CH; k++) begin
      if (load[k]) begin
        m_valid_d[k]                  = 1'b1;
        m_last_d[k]                   = s_last_i;
        m_data_d[k*DATA_W +: DATA_W]  = s_data_i;
      end else if (m_valid_q[k] && m_ready_i[k]) begin
        m_valid_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_valid_q <= '0;
      m_last_q  <= '0;
      m_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_last_o  = m_last_q;
  assign m_data_o  = m_data_q;

`ifdef STREAM_DEMUX_DROP_EN
  logic drop_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) drop_q <= 1'b0;
    else       drop_q <= accept && s_last_i && !in_range;
  end
  assign drop_o = drop_q;
`else
  assign drop_o = 1'b0;
`endif

endmodule
